// File: rtl/hrange_reduce_if.sv
// ----------------------------------------------------------------------------
// hrange_reduce_if
//   Caller-facing generator handshake bundle of hrange_reduce.
//
//   base/limit/step : range arguments, captured on an accepted _start
//   _start          : begin (accepted only while _wait=0)
//   _wait           : caller backpressure, holds the result yield
//   _valid          : one-cycle pulse, _0/_1/_err valid
//   _ready          : one-cycle pulse, operation done
//   _0 / _1         : sum / count of the reduced values
//   _err            : timeout abort flag, meaningful with _valid
//
//   master : the caller (drives arguments, _start, _wait)
//   slave  : the reducer (drives the result side)
// ----------------------------------------------------------------------------
interface hrange_reduce_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] step;
    logic             _start;
    logic             _wait;
    logic             _valid;
    logic             _ready;
    logic [WIDTH-1:0] _0;
    logic [WIDTH-1:0] _1;
    logic             _err;

    modport master (
        output base, limit, step, _start, _wait,
        input  _valid, _ready, _0, _1, _err
    );

    modport slave (
        input  base, limit, step, _start, _wait,
        output _valid, _ready, _0, _1, _err
    );
endinterface

// File: rtl/hrange_reduce.sv
// ----------------------------------------------------------------------------
// hrange_reduce
//   Launches a range generator (base, limit, step), consumes every value it
//   yields and folds it into a running sum and count. The result is offered
//   upstream with the same generator protocol: one yield (_0=sum, _1=count)
//   followed by a one-cycle done pulse on _ready.
//
//   Optional feature: define HRANGE_REDUCE_TIMEOUT_EN to abort COLLECT after
//   TIMEOUT_CYCLES consecutive cycles without a generator value; the partial
//   result is then yielded with _err=1. Without the macro _err is tied to 0.
//
// Ports
//   _clock        clock, rising edge
//   _reset        asynchronous active-low reset
//   up            hrange_reduce_if.slave, caller handshake and result
//   gen_base/gen_limit/gen_step  registered generator arguments
//   gen_start     generator start pulse (high during LAUNCH)
//   gen_wait      generator pause, low only in LAUNCH/COLLECT
//   gen_valid     generator yields gen_0 this cycle
//   gen_ready     generator finished
//   gen_0         yielded value
// ----------------------------------------------------------------------------
module hrange_reduce #(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 _clock,
    input  logic                 _reset,
    hrange_reduce_if.slave       up,
    output logic [WIDTH-1:0]     gen_base,
    output logic [WIDTH-1:0]     gen_limit,
    output logic [WIDTH-1:0]     gen_step,
    output logic                 gen_start,
    output logic                 gen_wait,
    input  logic                 gen_valid,
    input  logic                 gen_ready,
    input  logic [WIDTH-1:0]     gen_0
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        COLLECT,
        EMIT,
        DONE
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] cnt_reg;
    logic             start_accepted;

    assign start_accepted = up._start && !up._wait;

    // The generator may only run while we are launching it or collecting.
    assign gen_wait = !((state_reg == LAUNCH) || (state_reg == COLLECT));

`ifdef HRANGE_REDUCE_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer_reg;
    logic               err_reg;
    logic               timer_expired;

    // timer_reg holds the idle cycles already seen, so the current idle cycle
    // is the TIMEOUT_CYCLES-th one when it equals TIMEOUT_CYCLES-1.
    assign timer_expired = (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign up._err       = err_reg;
`else
    assign up._err = 1'b0;
`endif

    always_ff @(posedge _clock or negedge _reset) begin
        if (!_reset) begin
            state_reg  <= IDLE;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            up._valid  <= 1'b0;
            up._ready  <= 1'b0;
            up._0      <= '0;
            up._1      <= '0;
            gen_start  <= 1'b0;
            gen_base   <= '0;
            gen_limit  <= '0;
            gen_step   <= '0;
`ifdef HRANGE_REDUCE_TIMEOUT_EN
            timer_reg  <= '0;
            err_reg    <= 1'b0;
`endif
        end else begin
            up._valid <= 1'b0;
            up._ready <= 1'b0;
            gen_start <= 1'b0;

            if (start_accepted) begin
                // A new start wins over whatever was in flight; the aborted
                // operation never yields. gen_start is registered here so it
                // is high for exactly the LAUNCH cycle.
                gen_base  <= up.base;
                gen_limit <= up.limit;
                gen_step  <= up.step;
                gen_start <= 1'b1;
                acc_reg   <= '0;
                cnt_reg   <= '0;
`ifdef HRANGE_REDUCE_TIMEOUT_EN
                timer_reg <= '0;
                err_reg   <= 1'b0;
`endif
                state_reg <= LAUNCH;
            end else begin
                case (state_reg)
                    IDLE: begin
                    end

                    // Anything on gen_valid/gen_ready here belongs to a
                    // previous run of the generator and is dropped.
                    LAUNCH: state_reg <= COLLECT;

                    COLLECT: begin
                        if (gen_valid) begin
                            acc_reg   <= acc_reg + gen_0;
                            cnt_reg   <= cnt_reg + WIDTH'(1);
`ifdef HRANGE_REDUCE_TIMEOUT_EN
                            timer_reg <= '0;
                        end else begin
                            timer_reg <= timer_reg + TIMER_W'(1);
`endif
                        end

                        // A value arriving together with gen_ready is
                        // already folded in above.
                        if (gen_ready) begin
                            state_reg <= EMIT;
`ifdef HRANGE_REDUCE_TIMEOUT_EN
                        end else if (!gen_valid && timer_expired) begin
                            err_reg   <= 1'b1;
                            state_reg <= EMIT;
`endif
                        end
                    end

                    EMIT: begin
                        if (!up._wait) begin
                            up._0     <= acc_reg;
                            up._1     <= cnt_reg;
                            up._valid <= 1'b1;
                            state_reg <= DONE;
                        end
                    end

                    // Done follows the yield unconditionally, even under _wait.
                    DONE: begin
                        up._ready <= 1'b1;
                        state_reg <= IDLE;
                    end

                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/hrange_reduce.md
Name: hrange_reduce

Overview:
- Caller/consumer end of the generator handshake (`_start`/`_wait`/`_valid`/`_ready`/`_0`).
- Launches a range generator (base, limit, step), drives its `_wait`, and folds every yielded value into a running sum and count.
- Presents the result upstream through the same generator protocol: one yield of (`_0`=sum, `_1`=count), then a done pulse.
- Used wherever a function body calls a range generator and reduces its output.

Parameters:
- WIDTH, 32, width of base/limit/step/values/sum/count (signed two's complement).
- TIMEOUT_CYCLES, 64, idle cycles in COLLECT before abort; used only with the optional feature.

Ports:
- `_clock`  in  1  clock, rising edge.
- `_reset`  in  1  asynchronous active-low reset.
- `base`, `limit`, `step`  in  WIDTH each  range arguments, captured on accepted `_start`.
- `_start`  in  1  capture arguments and begin; honoured only when `_wait`=0.
- `_wait`  in  1  downstream backpressure; holds the result yield.
- `_ready`  out  1  one-cycle pulse, done.
- `_valid`  out  1  one-cycle pulse, `_0`/`_1` valid.
- `_0`  out  WIDTH  sum of yielded values.
- `_1`  out  WIDTH  count of yielded values.
- `_err`  out  1  timeout abort flag, valid with `_valid`; tied 0 without the macro.
- `gen_base`, `gen_limit`, `gen_step`  out  WIDTH each  registered generator arguments.
- `gen_start`  out  1  generator start.
- `gen_wait`  out  1  generator pause.
- `gen_valid`, `gen_ready`  in  1 each  from generator.
- `gen_0`  in  WIDTH  yielded value.

Behaviour:
- Reset (`_reset`=0, async):
  - state=IDLE.
  - acc=0, cnt=0.
  - `_valid`=0, `_ready`=0, `_0`=0, `_1`=0, `_err`=0.
  - `gen_start`=0, `gen_base`/`gen_limit`/`gen_step`=0.
- `_valid`, `_ready`, `gen_start` default to 0 every cycle; all are pulses.
- `gen_wait` is combinational from state: 0 in LAUNCH/COLLECT, 1 in IDLE/EMIT/DONE.
- States IDLE, LAUNCH, COLLECT, EMIT, DONE.
- Accepted `_start` (`_start`=1, `_wait`=0), from any state:
  - captures args into `gen_*`, clears acc/cnt/timer/err, next=LAUNCH.
  - Restarts an in-progress operation; the aborted operation emits nothing.
- LAUNCH:
  - `gen_start`=1 for exactly this cycle.
  - `gen_valid`/`gen_ready` ignored (stale).
  - next=COLLECT.
- COLLECT:
  - On `gen_valid`=1: acc<=acc+`gen_0`, cnt<=cnt+1, timer cleared. Both wrap modulo 2^WIDTH, no saturation.
  - On `gen_ready`=1: next=EMIT. If `gen_valid` is also 1 that cycle, the value is included.
- Latency: first generator value arrives 2 cycles after the accepted `_start` edge.
- EMIT:
  - If `_wait`=0: `_0`<=acc, `_1`<=cnt, `_valid`<=1, next=DONE.
  - Else hold; `_0`/`_1` unchanged and `_valid` stays 0.
- DONE: `_ready`<=1 for one cycle, next=IDLE.
  - `_ready` follows `_valid` by exactly 1 cycle regardless of `_wait`.
- Empty range (generator gives `gen_ready` with no `gen_valid`): result `_0`=0, `_1`=0.
- `_start` while `_wait`=1 is ignored entirely.
- Reset asserted mid-operation: immediate return to IDLE; no pulse emitted.
- `_0`/`_1` retain the last result until the next result.

Optional Feature:
- Macro: HRANGE_REDUCE_TIMEOUT_EN.
- Defined:
  - Timer counts COLLECT cycles without `gen_valid`.
  - At TIMEOUT_CYCLES: next=EMIT with `_err`=1.
  - Emits the partial sum/count with `_err` asserted alongside `_valid`; `_err` clears on the next accepted `_start`.
- Undefined: no timer; COLLECT waits indefinitely; `_err` constant 0.

Test Plan:
- base=0, limit=5, step=1, behavioural generator → `_valid` with `_0`=10, `_1`=5, `_err`=0; `_ready` the next cycle; `gen_start` a single pulse 1 cycle after `_start`.
- base=3, limit=3, step=1 → `_0`=0, `_1`=0, `_valid` then `_ready`.
- base=0x7FFFFFF0, limit=0x7FFFFFFF, step=8 → values 0x7FFFFFF0, 0x7FFFFFF8; `_0`=0xFFFFFFE8 (wrapped), `_1`=2.
- `_wait` held high 4 cycles when entering EMIT (0..5 step 1) → no `_valid` and `gen_wait`=1 during the hold; `_valid` with 10/5 on the first cycle after release.
- Restart: `_start` (0,100,1), then `_start` (0,4,2) after 3 values → single result `_0`=2, `_1`=2; `_start` with `_wait`=1 ignored.
- Macro on, TIMEOUT_CYCLES=8, generator stalls after yielding 7 → after 8 idle cycles `_valid`, `_err`=1, `_0`=7, `_1`=1. Plus async `_reset` pulse mid-COLLECT → all outputs 0, state IDLE, no `_valid`.
